fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 21 ++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: decode-side handshake and instruction-memory bus of the fetch stage
interface fetch_unit_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        valid_out;
    logic [31:0] pc_plus4_out;
    logic [31:0] inst_out;
    modport master (
        input  stall, redirect, redirect_pc, imem_valid, imem_rdata,
        output imem_req, imem_addr, valid_out, pc_plus4_out, inst_out
    );
    modport slave (
        output stall, redirect, redirect_pc, imem_valid, imem_rdata,
        input  imem_req, imem_addr, valid_out, pc_plus4_out, inst_out
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with one-entry skid buffer, redirect flush and stale-response drop
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_addr, r_inst, r_pc4, r_sk_inst, r_sk_pc4;
    logic [31:0] w_pc_nxt, w_pc4, w_rpc;
    logic        r_valid, r_drop, w_drop_nxt, w_req, w_xfer, w_consume, w_to_skid;
    assign w_req     = (r_state == FETCH) && !r_drop;
    assign w_xfer    = w_req && bus.imem_valid;
    assign w_consume = r_valid && !bus.stall;
    assign w_to_skid = w_xfer && r_valid && bus.stall;
    assign w_pc4     = r_pc + 32'd4;
    assign w_rpc     = bus.redirect_pc & ~32'h3;
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop && !bus.imem_valid;
        if (bus.redirect) begin
            w_state_nxt = FETCH;
            w_pc_nxt    = w_rpc;
            // a request already seen by memory must have its response swallowed
            w_drop_nxt  = (w_req || r_drop) && !bus.imem_valid;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = FETCH;
                FETCH:   begin
                    w_pc_nxt    = w_xfer ? w_pc4 : r_pc;
                    w_state_nxt = w_to_skid ? HOLD : FETCH;
                end
                HOLD:    w_state_nxt = w_consume ? FETCH : HOLD;
                default: w_state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_addr    <= 32'h0;
            r_drop    <= 1'b0;
            r_valid   <= 1'b0;
            r_inst    <= 32'h0;
            r_pc4     <= 32'h0;
            r_sk_inst <= 32'h0;
            r_sk_pc4  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            if (bus.redirect) begin
                r_valid   <= 1'b0;
                r_inst    <= 32'h0;
                r_pc4     <= 32'h0;
                r_sk_inst <= 32'h0;
                r_sk_pc4  <= 32'h0;
            end else begin
                if (w_to_skid) begin
                    r_sk_inst <= bus.imem_rdata;
                    r_sk_pc4  <= w_pc4;
                end
                if (r_state == HOLD && w_consume) begin
                    r_inst <= r_sk_inst;
                    r_pc4  <= r_sk_pc4;
                end else if (w_xfer && !w_to_skid) begin
                    r_valid <= 1'b1;
                    r_inst  <= bus.imem_rdata;
                    r_pc4   <= w_pc4;
                end else if (w_consume) begin
                    r_valid <= 1'b0;
                    r_inst  <= 32'h0;
                end
            end
        end
    end
    assign bus.imem_req     = w_req;
    assign bus.imem_addr    = r_addr;
    assign bus.valid_out    = r_valid;
    assign bus.inst_out     = r_inst;
    assign bus.pc_plus4_out = r_pc4;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus against a queue-based model of the fetch stream
module tb_fetch_unit;
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } slot_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        zw = 1'b1;
    logic        lat_rand = 1'b0;
    logic        busy = 1'b0;
    logic [1:0]  cnt = 2'd0;
    logic [31:0] maddr = 32'h0;
    int          total = 0;
    int          bad = 0;
    int          n_push = 0;
    int          n0;
    int          idle = 0;
    logic        m_rst = 1'b1;
    logic        z = 1'b1;
    logic [31:0] fpc = 32'h0;
    slot_t       q[$];
    always #5 clk = ~clk;
    fetch_unit_if bus ();
    fetch_unit_if bus2 ();
    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus.master));
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));
    // memory: zero-wait when zw, otherwise one outstanding request with 1..3 cycle latency
    assign bus.imem_valid  = zw ? bus.imem_req : (busy && cnt == 2'd0);
    assign bus.imem_rdata  = (zw ? bus.imem_addr : maddr) + 32'h100;
    assign bus2.stall       = 1'b0;
    assign bus2.redirect    = 1'b0;
    assign bus2.redirect_pc = 32'h0;
    assign bus2.imem_valid  = bus2.imem_req;
    assign bus2.imem_rdata  = bus2.imem_addr + 32'h100;
    always @(posedge clk) begin
        if (rst || zw) busy <= 1'b0;
        else if (busy) begin
            if (cnt == 2'd0) busy <= 1'b0;
            else cnt <= cnt - 2'd1;
        end else if (bus.imem_req) begin
            busy  <= 1'b1;
            cnt   <= lat_rand ? 2'($urandom_range(2, 0)) : 2'd1;
            maddr <= bus.imem_addr;
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // scoreboard: a transfer pushes the word the fetch stream should deliver, consumption pops it
    always @(negedge clk) begin
        if (m_rst) begin
            chk("rst_valid", 32'(bus.valid_out), 32'h0);
            chk("rst_inst", bus.inst_out, 32'h0);
            chk("rst_pc4", bus.pc_plus4_out, 32'h0);
            chk("rst_req", 32'(bus.imem_req), 32'h0);
            chk("rst_addr", bus.imem_addr, 32'h0);
        end else begin
            chk("valid_out", 32'(bus.valid_out), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("inst_out", bus.inst_out, q[0].inst);
                chk("pc_plus4", bus.pc_plus4_out, q[0].pc4);
            end else begin
                chk("nop_inst", bus.inst_out, 32'h0);
                if (z) chk("flush_pc4", bus.pc_plus4_out, 32'h0);
            end
            if (q.size() >= 2) chk("hold_no_req", 32'(bus.imem_req), 32'h0);
        end
        m_rst = rst;
        if (rst) begin
            q.delete();
            fpc  = 32'h0;
            z    = 1'b1;
            idle = 0;
        end else if (bus.redirect) begin
            q.delete();
            fpc  = {bus.redirect_pc[31:2], 2'b00};
            z    = 1'b1;
            idle = 0;
        end else begin
            if (q.size() != 0 && !bus.stall) void'(q.pop_front());
            if (bus.imem_req && bus.imem_valid) begin
                chk("fetch_addr", bus.imem_addr, fpc);
                q.push_back('{fpc + 32'h100, fpc + 32'd4});
                fpc = fpc + 32'd4;
                z   = 1'b0;
                n_push++;
                idle = 0;
            end else if (!bus.stall) begin
                idle++;
                if (idle > 30) begin
                    total++;
                    bad++;
                    $display("FAIL watchdog: no fetch progress for %0d cycles at %0t", idle, $time);
                    idle = 0;
                end
            end
        end
    end
    initial begin
        @(negedge rst);
        @(posedge clk);
        @(negedge clk);
        chk("rpc_first_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        chk("rpc_first_req", 32'(bus2.imem_req), 32'h1);
        @(negedge clk);
        chk("rpc_wrap_valid", 32'(bus2.valid_out), 32'h1);
        chk("rpc_wrap_pc4", bus2.pc_plus4_out, 32'h0);
        chk("rpc_wrap_inst", bus2.inst_out, 32'h0000_00FC);
        chk("rpc_second_addr", bus2.imem_addr, 32'h0);
    end
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
    initial begin
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        n0 = n_push;
        repeat (8) tick;
        chk("throughput", 32'(n_push - n0), 32'd8);
        bus.stall = 1'b1;
        repeat (3) tick;
        chk("hold_req", 32'(bus.imem_req), 32'h0);
        chk("hold_valid", 32'(bus.valid_out), 32'h1);
        bus.stall = 1'b0;
        repeat (4) tick;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0042;
        tick;
        bus.redirect = 1'b0;
        chk("redir_valid", 32'(bus.valid_out), 32'h0);
        chk("redir_inst", bus.inst_out, 32'h0);
        chk("redir_addr", bus.imem_addr, 32'h0000_0040);
        repeat (3) tick;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        tick;
        bus.redirect = 1'b0;
        repeat (4) tick;
        bus.stall = 1'b1;
        repeat (2) tick;
        chk("skid_full_req", 32'(bus.imem_req), 32'h0);
        rst = 1'b1;
        tick;
        bus.stall = 1'b0;
        rst = 1'b0;
        tick;
        chk("rst_refetch_addr", bus.imem_addr, 32'h0);
        chk("rst_refetch_req", 32'(bus.imem_req), 32'h1);
        rst = 1'b1;
        zw = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h10;
        tick;
        bus.redirect = 1'b0;
        for (int i = 0; i < 20 && !(bus.imem_req && bus.imem_addr == 32'h10); i++) tick;
        chk("req_0x10", 32'(bus.imem_req && bus.imem_addr == 32'h10), 32'h1);
        tick;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h200;
        tick;
        bus.redirect = 1'b0;
        chk("drop_req_low", 32'(bus.imem_req), 32'h0);
        for (int i = 0; i < 20 && !bus.valid_out; i++) tick;
        chk("drop_valid", 32'(bus.valid_out), 32'h1);
        chk("drop_pc4", bus.pc_plus4_out, 32'h204);
        chk("drop_inst", bus.inst_out, 32'h300);
        lat_rand = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 700; i++) begin
                rst = ($urandom_range(99, 0) == 0);
                bus.stall = ($urandom_range(99, 0) < 30);
                bus.redirect = ($urandom_range(99, 0) < 5);
                bus.redirect_pc = $urandom;
                tick;
            end
            bus.stall = 1'b0;
            bus.redirect = 1'b0;
            rst = 1'b1;
            tick;
            zw = 1'b1;
            rst = 1'b0;
            tick;
        end
        repeat (5) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
